// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_stage: RV32I decode with valid/ready handshake and writeback      |
// | scoreboard that stalls on pending sources.   Revision: 1.0               |
// +--------------------------------------------------------------------------+
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [4:0]      rs1_address,
  output logic [4:0]      rs2_address,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic [XLEN-1:0] imm,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        use_rs1, use_rs2, writes, is_illegal;
  logic [31:0] imm_next;
  logic [4:0]  rs1_next, rs2_next, rd_next;
  logic        reg_write_next;
  logic [31:0] sb, sb_eff, sb_next, wb_mask, kill_mask, set_mask;
  logic        hazard, accept;

  always_comb begin
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    writes     = 1'b0;
    is_illegal = 1'b0;
    imm_next   = 32'd0;
    case (instr[6:0])
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        writes  = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1  = 1'b1;
        writes   = 1'b1;
        imm_next = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        imm_next = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        imm_next = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        writes   = 1'b1;
        imm_next = {instr[31:12], 12'd0};
      end
      OP_JAL: begin
        writes   = 1'b1;
        imm_next = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: is_illegal = 1'b1;
    endcase
  end

  assign rs1_next       = use_rs1 ? instr[19:15] : 5'd0;
  assign rs2_next       = use_rs2 ? instr[24:20] : 5'd0;
  assign rd_next        = instr[11:7];
  assign reg_write_next = writes && (rd_next != 5'd0);

  // Same-cycle writeback is bypassed so a stall releases in the cycle it clears.
  assign wb_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;
  assign sb_eff  = sb & ~wb_mask;
  assign hazard  = (use_rs1 && sb_eff[rs1_next]) || (use_rs2 && sb_eff[rs2_next]);

  assign instr_ready = (!dec_valid || dec_ready) && !hazard && !flush;
  assign accept      = instr_valid && instr_ready;

  // Set is applied last so it wins over any clear of the same index.
  assign kill_mask = (flush && dec_valid && reg_write) ? (32'd1 << rd) : 32'd0;
  assign set_mask  = (accept && reg_write_next) ? (32'd1 << rd_next) : 32'd0;
  assign sb_next   = ((sb_eff & ~kill_mask) | set_mask) & 32'hFFFF_FFFE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb          <= 32'd0;
      dec_valid   <= 1'b0;
      rs1_address <= 5'd0;
      rs2_address <= 5'd0;
      rd          <= 5'd0;
      reg_write   <= 1'b0;
      imm         <= '0;
      opcode      <= 7'd0;
      funct3      <= 3'd0;
      funct7      <= 7'd0;
      illegal     <= 1'b0;
    end else begin
      sb <= sb_next;
      if (flush) begin
        dec_valid <= 1'b0;
      end else if (accept) begin
        dec_valid <= 1'b1;
      end else if (dec_ready) begin
        dec_valid <= 1'b0;
      end
      if (accept) begin
        rs1_address <= rs1_next;
        rs2_address <= rs2_next;
        rd          <= rd_next;
        reg_write   <= reg_write_next;
        imm         <= imm_next;
        opcode      <= instr[6:0];
        funct3      <= instr[14:12];
        funct7      <= instr[31:25];
        illegal     <= is_illegal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_stage: directed plus random stimulus against a reference model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, dec_ready, wb_valid, flush;
  logic [31:0] instr;
  logic [4:0]  wb_rd;
  logic        instr_ready, dec_valid, reg_write, illegal;
  logic [4:0]  rs1_address, rs2_address, rd;
  logic [31:0] imm;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .rs1_address(rs1_address), .rs2_address(rs2_address), .rd(rd),
    .reg_write(reg_write), .imm(imm), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .illegal(illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  typedef struct packed {
    logic        u1;
    logic        u2;
    logic        wr;
    logic        ill;
    logic [31:0] imm;
  } dec_t;

  // Reference state: what downstream should see and which writebacks are pending.
  logic        m_valid, m_rw, m_ill;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_imm, m_instr, m_sb;

  function automatic dec_t model_dec(input logic [31:0] i);
    dec_t d;
    int   v;
    d = '0;
    case (i[6:0])
      7'b0110011: begin d.u1 = 1; d.u2 = 1; d.wr = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        d.u1 = 1; d.wr = 1;
        v = $signed(i[31:20]);
        d.imm = v;
      end
      7'b0100011: begin
        d.u1 = 1; d.u2 = 1;
        v = $signed({i[31:25], i[11:7]});
        d.imm = v;
      end
      7'b1100011: begin
        d.u1 = 1; d.u2 = 1;
        v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
        d.imm = v;
      end
      7'b0110111, 7'b0010111: begin
        d.wr = 1;
        d.imm = i[31:12] * 32'd4096;
      end
      7'b1101111: begin
        d.wr = 1;
        v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
        d.imm = v;
      end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_ill = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_imm = 0; m_instr = 0; m_sb = 0;
  endtask

  task automatic check_all();
    chk("dec_valid", dec_valid, m_valid);
    chk("rs1_address", rs1_address, m_rs1);
    chk("rs2_address", rs2_address, m_rs2);
    chk("rd", rd, m_rd);
    chk("reg_write", reg_write, m_rw);
    chk("imm", imm, m_imm);
    chk("opcode", opcode, m_instr[6:0]);
    chk("funct3", funct3, m_instr[14:12]);
    chk("funct7", funct7, m_instr[31:25]);
    chk("illegal", illegal, m_ill);
    chk("scoreboard", dut.sb, m_sb);
  endtask

  // One clock: check readiness before the edge, advance the model, check after.
  task automatic step();
    dec_t        d;
    logic [31:0] sbe, sbn;
    logic        hz, rdy, acc;
    #1;
    d   = model_dec(instr);
    sbe = m_sb;
    if (wb_valid) sbe[wb_rd] = 1'b0;
    hz  = (d.u1 && sbe[instr[19:15]]) || (d.u2 && sbe[instr[24:20]]);
    rdy = (!m_valid || dec_ready) && !hz && !flush;
    chk("instr_ready", instr_ready, rdy);
    acc = instr_valid && rdy;
    sbn = sbe;
    if (flush && m_valid && m_rw) sbn[m_rd] = 1'b0;
    if (acc && d.wr && instr[11:7] != 0) sbn[instr[11:7]] = 1'b1;
    sbn[0] = 1'b0;
    m_sb = sbn;
    if (flush) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (dec_ready) m_valid = 0;
    if (acc) begin
      m_rs1   = d.u1 ? instr[19:15] : 5'd0;
      m_rs2   = d.u2 ? instr[24:20] : 5'd0;
      m_rd    = instr[11:7];
      m_rw    = d.wr && instr[11:7] != 0;
      m_imm   = d.imm;
      m_ill   = d.ill;
      m_instr = instr;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic dr,
                       input logic wv, input logic [4:0] wr, input logic fl);
    instr_valid = v; instr = i; dec_ready = dr; wb_valid = wv; wb_rd = wr; flush = fl;
  endtask

  logic [6:0]  ops [10];
  logic [31:0] r;
  logic [4:0]  a1, a2, ad;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
    rst_n = 1'b0;
    drive(0, 32'd0, 0, 0, 5'd0, 0);
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,5
    drive(1, 32'h00500093, 1, 0, 5'd0, 0);
    step();
    chk("addi_valid", dec_valid, 1); chk("addi_rd", rd, 1); chk("addi_rs1", rs1_address, 0);
    chk("addi_rs2", rs2_address, 0); chk("addi_imm", imm, 5); chk("addi_rw", reg_write, 1);
    chk("addi_sb1", dut.sb[1], 1);

    // add x2,x1,x1 stalls until x1 writes back, then accepts in that cycle
    drive(1, 32'h00108133, 1, 0, 5'd0, 0);
    step();
    chk("add_stalled", instr_ready, 0);
    drive(1, 32'h00108133, 1, 1, 5'd1, 0);
    step();
    chk("add_rs1", rs1_address, 1); chk("add_rs2", rs2_address, 1);
    chk("add_rd", rd, 2); chk("add_imm", imm, 0);

    // sw x2,8(x1) with x2 cleared by a same-cycle writeback
    drive(1, 32'h0020A423, 1, 1, 5'd2, 0);
    step();
    chk("sw_rs1", rs1_address, 1); chk("sw_rs2", rs2_address, 2); chk("sw_imm", imm, 8);
    chk("sw_rw", reg_write, 0); chk("sw_sb", dut.sb, 0);

    drive(1, 32'hFE000EE3, 1, 0, 5'd0, 0);
    step();
    chk("beq_imm", imm, 32'hFFFFFFFC);
    drive(1, 32'h123452B7, 1, 0, 5'd0, 0);
    step();
    chk("lui_imm", imm, 32'h12345000); chk("lui_rd", rd, 5);

    drive(1, 32'h0000007F, 1, 1, 5'd5, 0);
    step();
    chk("ill_flag", illegal, 1); chk("ill_rw", reg_write, 0); chk("ill_valid", dec_valid, 1);
    chk("ill_sb", dut.sb, 0);

    // addi x3,x0,1 held, then flushed
    drive(1, 32'h00100193, 1, 0, 5'd0, 0);
    step();
    drive(0, 32'h00100193, 0, 0, 5'd0, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("hold_rd", rd, 3); chk("hold_valid", dec_valid, 1);
    end
    drive(1, 32'h00200213, 0, 0, 5'd0, 1);
    #1 chk("flush_ready", instr_ready, 0);
    step();
    chk("flush_valid", dec_valid, 0); chk("flush_sb3", dut.sb[3], 0);

    for (int n = 0; n < 400; n++) begin
      r  = $urandom();
      a1 = 5'($urandom_range(0, 3));
      a2 = 5'($urandom_range(0, 3));
      ad = 5'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 3) != 0),
            {r[31:25], a2, a1, r[14:12], ad, ops[$urandom_range(0, 9)]},
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) < 2),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 15) == 0));
      step();
    end

    // Asynchronous reset while an instruction is held
    drive(1, 32'h00100193, 1, 0, 5'd0, 0);
    step();
    drive(0, 32'd0, 0, 0, 5'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h00500093, 1, 0, 5'd0, 0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
